control_fsm: RTL
================

CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 SHALL have clk_i, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have rst_i, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have opcode_i, input, 7: opcode field of the instruction register.
REQ-005 SHALL have zero_i, input, 1: ALU zero flag, sampled in EXECUTE for branches.
REQ-006 SHALL have mem_ready_i, input, 1: memory completes the current read or write this cycle.
REQ-007 SHALL have pcwrite_o, irwrite_o, regwrite_o, alusrc_o, memread_o, memwrite_o, memtoreg_o, branch_o, each output, 1: datapath controls.
REQ-008 SHALL have state_o, output, 3: current state encoding.
REQ-009 SHALL have instret_o, output, CNT_W: count of retired instructions.
REQ-010 SHALL have illegal_o, output, 1: illegal-opcode trap flag (driven only under REQ-026).

Function
REQ-011 States SHALL be FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP; outputs SHALL be Moore-decoded from the state and the latched opcode, except pcwrite_o/irwrite_o in FETCH and pcwrite_o in EXECUTE.
REQ-012 FETCH SHALL assert memread_o and wait; on mem_ready_i=1 it SHALL assert irwrite_o and pcwrite_o for exactly that cycle and go to DECODE.
REQ-013 DECODE SHALL latch opcode_i into an internal register; R (0110011), I (0010011), S (0100011), L (0000011), B (1100011) SHALL go to EXECUTE; any other opcode SHALL go to FETCH, without retiring.
REQ-014 EXECUTE SHALL drive alusrc_o=0 for R and B, 1 for I, S, L.
REQ-015 EXECUTE: R and I SHALL go to WRITEBACK; S and L SHALL go to MEM; B SHALL assert branch_o=1 and pcwrite_o=zero_i, then go to FETCH and retire.
REQ-016 MEM: L SHALL assert memread_o; S SHALL assert memwrite_o; both SHALL hold until mem_ready_i=1. L SHALL then go to WRITEBACK; S SHALL go to FETCH and retire.
REQ-017 WRITEBACK SHALL assert regwrite_o, with memtoreg_o=1 only for L, then go to FETCH and retire.
REQ-018 Retire SHALL increment instret_o by 1 on the transition edge; instret_o SHALL wrap from all-ones to 0.
REQ-019 Latency, zero-wait memory: R/I 5 cycles, L 6, S 5, B 4.
REQ-020 Each memory wait state SHALL add one cycle.
REQ-021 Any control output not named for a state SHALL be 0 in that state.
REQ-022 Changes on opcode_i outside DECODE SHALL have no effect.

Reset
REQ-023 While rst_i=1, all outputs SHALL be 0, the state SHALL be FETCH, instret_o SHALL be 0, the opcode register SHALL be 0000000, and illegal_o SHALL be 0.
REQ-024 rst_i asserted in any state, including a MEM wait or TRAP, SHALL abort the instruction with no retire.
REQ-025 The first cycle after rst_i falls SHALL be FETCH with memread_o=1.

Configuration
REQ-026 With ILLEGAL_TRAP_EN defined, an unknown opcode in DECODE SHALL go to TRAP and hold illegal_o=1 and all other controls 0 until reset.
REQ-027 Without ILLEGAL_TRAP_EN, TRAP SHALL be unreachable, illegal_o SHALL be tied 0, and REQ-013's return to FETCH SHALL apply.

Structure
REQ-028 Package ctrl_pkg SHALL hold the opcode constants for the R, I, S, L and B classes and the state enumeration (3 bits; TRAP = 3'b101).
REQ-029 Sub-module opcode_class SHALL be used: combinational mapping of 7-bit opcode to a class code {R, I, S, L, B, BAD}.
REQ-030 The FSM and counter SHALL remain in control_fsm.

Verification
REQ-031 Reset, then opcode 0110011, mem_ready_i=1 -> states FETCH, DECODE, EXECUTE, WRITEBACK, FETCH; regwrite_o=1 only in WRITEBACK; instret_o=1.
REQ-032 Opcode 0000011, mem_ready_i low 3 cycles in MEM -> memread_o held 4 cycles; WRITEBACK with memtoreg_o=1; total 9 cycles.
REQ-033 Opcode 1100011, zero_i=1, then zero_i=0 -> EXECUTE pcwrite_o=1 then 0; branch_o=1 both times; instret_o +2.
REQ-034 Opcode 0100011 with rst_i pulsed during MEM wait -> memwrite_o drops the same edge; state FETCH; instret_o=0.
REQ-035 Opcode 1111111 -> with ILLEGAL_TRAP_EN, state_o=101 and illegal_o=1 held 10 cycles; without it, back to FETCH and instret_o unchanged.
REQ-036 CNT_W=4, retire 16 R-type instructions -> instret_o wraps to 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control FSM: opcode constants, state
// encoding and the opcode class codes produced by opcode_class.
package ctrl_pkg;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_B = 7'b1100011;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'b000,
        ST_DECODE    = 3'b001,
        ST_EXECUTE   = 3'b010,
        ST_MEM       = 3'b011,
        ST_WRITEBACK = 3'b100,
        ST_TRAP      = 3'b101
    } state_t;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_I   = 3'd1,
        CLS_S   = 3'd2,
        CLS_L   = 3'd3,
        CLS_B   = 3'd4,
        CLS_BAD = 3'd5
    } op_class_t;

endpackage

// File: rtl/opcode_class.sv
// Combinational map from a 7-bit opcode to its instruction class; anything not
// recognised is CLS_BAD. Zero latency, no flow control.
module opcode_class
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  op_class
);

    always_comb begin
        case (opcode)
            OP_R:    op_class = CLS_R;
            OP_I:    op_class = CLS_I;
            OP_S:    op_class = CLS_S;
            OP_L:    op_class = CLS_L;
            OP_B:    op_class = CLS_B;
            default: op_class = CLS_BAD;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle CPU control FSM with retired-instruction counter; memory stalls via mem_ready_i.
// Define ILLEGAL_TRAP_EN to park unknown opcodes in TRAP (illegal_o=1) until reset.
module control_fsm
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [6:0]       opcode_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             pcwrite_o,
    output logic             irwrite_o,
    output logic             regwrite_o,
    output logic             alusrc_o,
    output logic             memread_o,
    output logic             memwrite_o,
    output logic             memtoreg_o,
    output logic             branch_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instret_o,
    output logic             illegal_o
);

    state_t           state;
    logic [6:0]       op_q;
    logic [CNT_W-1:0] instret_q;
    op_class_t        dec_cls;
    op_class_t        cur_cls;

    // Live opcode classifies the DECODE branch; the latched copy drives later states.
    opcode_class u_dec_class (.opcode(opcode_i), .op_class(dec_cls));
    opcode_class u_cur_class (.opcode(op_q),     .op_class(cur_cls));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_FETCH;
            op_q      <= '0;
            instret_q <= '0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (mem_ready_i) state <= ST_DECODE;
                end
                ST_DECODE: begin
                    op_q <= opcode_i;
                    if (dec_cls == CLS_BAD) begin
`ifdef ILLEGAL_TRAP_EN
                        state <= ST_TRAP;
`else
                        state <= ST_FETCH;
`endif
                    end else begin
                        state <= ST_EXECUTE;
                    end
                end
                ST_EXECUTE: begin
                    case (cur_cls)
                        CLS_R, CLS_I: state <= ST_WRITEBACK;
                        CLS_S, CLS_L: state <= ST_MEM;
                        default: begin
                            state     <= ST_FETCH;
                            instret_q <= instret_q + CNT_W'(1);
                        end
                    endcase
                end
                ST_MEM: begin
                    if (mem_ready_i) begin
                        if (cur_cls == CLS_L) begin
                            state <= ST_WRITEBACK;
                        end else begin
                            state     <= ST_FETCH;
                            instret_q <= instret_q + CNT_W'(1);
                        end
                    end
                end
                ST_WRITEBACK: begin
                    state     <= ST_FETCH;
                    instret_q <= instret_q + CNT_W'(1);
                end
`ifdef ILLEGAL_TRAP_EN
                ST_TRAP: state <= ST_TRAP;
`endif
                default: state <= ST_FETCH;
            endcase
        end
    end

    // Reset forces every output low combinationally, independent of the state register.
    always_comb begin
        pcwrite_o  = 1'b0;
        irwrite_o  = 1'b0;
        regwrite_o = 1'b0;
        alusrc_o   = 1'b0;
        memread_o  = 1'b0;
        memwrite_o = 1'b0;
        memtoreg_o = 1'b0;
        branch_o   = 1'b0;
        illegal_o  = 1'b0;
        if (!rst_i) begin
            case (state)
                ST_FETCH: begin
                    memread_o = 1'b1;
                    irwrite_o = mem_ready_i;
                    pcwrite_o = mem_ready_i;
                end
                ST_EXECUTE: begin
                    alusrc_o = (cur_cls == CLS_I) || (cur_cls == CLS_S) || (cur_cls == CLS_L);
                    if (cur_cls == CLS_B) begin
                        branch_o  = 1'b1;
                        pcwrite_o = zero_i;
                    end
                end
                ST_MEM: begin
                    memread_o  = (cur_cls == CLS_L);
                    memwrite_o = (cur_cls == CLS_S);
                end
                ST_WRITEBACK: begin
                    regwrite_o = 1'b1;
                    memtoreg_o = (cur_cls == CLS_L);
                end
`ifdef ILLEGAL_TRAP_EN
                ST_TRAP: illegal_o = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign state_o   = rst_i ? ST_FETCH : state;
    assign instret_o = rst_i ? '0 : instret_q;

endmodule
